// File: rtl/fighter_input_arbiter.sv
// fighter_input_arbiter
// Turns debounced button presses from two players into single action
// commands. Each player has edge detection, a priority encoder, a one-deep
// pending buffer and an attack cooldown timer. A round-robin arbiter shares
// one command port into the game logic.
//
// Command port handshake: cmd_valid/cmd_player/cmd_code are registered and
// held stable while cmd_valid && !cmd_ready; a command transfers on every
// rising clock edge where cmd_valid && cmd_ready. The command register
// accepts a new command whenever !cmd_valid || cmd_ready.
module fighter_input_arbiter #(
    parameter int COOLDOWN_CYCLES = 50
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] p1_buttons,
    input  logic [3:0] p2_buttons,
    input  logic       cmd_ready,
    output logic       cmd_valid,
    output logic       cmd_player,
    output logic [1:0] cmd_code,
    output logic       p1_drop,
    output logic       p2_drop,
    output logic       p1_cooldown,
    output logic       p2_cooldown
);

    // A zero-cycle cooldown still needs a one-bit counter to stay legal.
    localparam int CW = (COOLDOWN_CYCLES > 0) ? $clog2(COOLDOWN_CYCLES + 1) : 1;
    localparam logic [CW-1:0] CD_LOAD = CW'(COOLDOWN_CYCLES);
    localparam logic [1:0] CODE_ATTACK = 2'd3;

    // Index 0 is player 1, index 1 is player 2.
    logic [1:0][3:0]    btn;
    logic [1:0][3:0]    prev_q, prev_d;
    logic [1:0]         pend_v_q, pend_v_d;
    logic [1:0][1:0]    pend_c_q, pend_c_d;
    logic [1:0][CW-1:0] cool_q, cool_d;
    logic [1:0]         drop_q, drop_d;
    logic               cmd_valid_q, cmd_valid_d;
    logic               cmd_player_q, cmd_player_d;
    logic [1:0]         cmd_code_q, cmd_code_d;
    logic               last_q, last_d;

    logic               loadable;
    logic [1:0]         gnt;
    logic [1:0][3:0]    press;
    logic [1:0]         has_press;
    logic [1:0][1:0]    enc_code;
    logic               handshake;

    assign btn = {p2_buttons, p1_buttons};

    // Next-state logic: arbitration, pending buffers, edge detect, cooldowns.
    always_comb begin
        prev_d       = btn;
        pend_v_d     = pend_v_q;
        pend_c_d     = pend_c_q;
        cool_d       = cool_q;
        drop_d       = '0;
        cmd_valid_d  = cmd_valid_q;
        cmd_player_d = cmd_player_q;
        cmd_code_d   = cmd_code_q;
        last_d       = last_q;
        press        = '0;
        has_press    = '0;
        enc_code     = '0;
        gnt          = '0;

        loadable  = !cmd_valid_q || cmd_ready;
        handshake = cmd_valid_q && cmd_ready;

        // Round robin: on a tie the player that was not granted last wins.
        if (loadable) begin
            if (pend_v_q == 2'b11) begin
                gnt = last_q ? 2'b01 : 2'b10;
            end else begin
                gnt = pend_v_q;
            end
        end

        if (gnt != 2'b00) begin
            cmd_valid_d  = 1'b1;
            cmd_player_d = gnt[1];
            cmd_code_d   = gnt[1] ? pend_c_q[1] : pend_c_q[0];
            last_d       = gnt[1];
        end else if (loadable) begin
            cmd_valid_d = 1'b0;
        end

        for (int p = 0; p < 2; p++) begin
            press[p] = btn[p] & ~prev_q[p];
            // Attacks during cooldown are ignored outright, not counted as drops.
            if (cool_q[p] != '0) begin
                press[p][3] = 1'b0;
            end
            has_press[p] = |press[p];
            if (press[p][3]) begin
                enc_code[p] = 2'd3;
            end else if (press[p][2]) begin
                enc_code[p] = 2'd2;
            end else if (press[p][1]) begin
                enc_code[p] = 2'd1;
            end else begin
                enc_code[p] = 2'd0;
            end

            if (gnt[p]) begin
                pend_v_d[p] = 1'b0;
            end
            // A slot being granted this cycle frees room for the new press.
            if (has_press[p]) begin
                if (!pend_v_q[p] || gnt[p]) begin
                    pend_v_d[p] = 1'b1;
                    pend_c_d[p] = enc_code[p];
                end else begin
                    drop_d[p] = 1'b1;
                end
            end

            if (handshake && (cmd_code_q == CODE_ATTACK) && (cmd_player_q == 1'(p))) begin
                cool_d[p] = CD_LOAD;
            end else if (cool_q[p] != '0) begin
                cool_d[p] = cool_q[p] - CW'(1);
            end
        end
    end

    // State registers, cleared asynchronously.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            prev_q       <= '0;
            pend_v_q     <= '0;
            pend_c_q     <= '0;
            cool_q       <= '0;
            drop_q       <= '0;
            cmd_valid_q  <= 1'b0;
            cmd_player_q <= 1'b0;
            cmd_code_q   <= 2'd0;
            last_q       <= 1'b1;
        end else begin
            prev_q       <= prev_d;
            pend_v_q     <= pend_v_d;
            pend_c_q     <= pend_c_d;
            cool_q       <= cool_d;
            drop_q       <= drop_d;
            cmd_valid_q  <= cmd_valid_d;
            cmd_player_q <= cmd_player_d;
            cmd_code_q   <= cmd_code_d;
            last_q       <= last_d;
        end
    end

    assign cmd_valid   = cmd_valid_q;
    assign cmd_player  = cmd_player_q;
    assign cmd_code    = cmd_code_q;
    assign p1_drop     = drop_q[0];
    assign p2_drop     = drop_q[1];
    assign p1_cooldown = (cool_q[0] != '0);
    assign p2_cooldown = (cool_q[1] != '0);

endmodule

// File: tb/tb_fighter_input_arbiter.sv
// Bench for fighter_input_arbiter: directed scenarios followed by random
// traffic, all compared against a queue-based reference model.
module tb_fighter_input_arbiter;

    localparam int C = 4;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] p1_buttons = '0;
    logic [3:0] p2_buttons = '0;
    logic       cmd_ready = 1'b0;
    logic       cmd_valid, cmd_player;
    logic [1:0] cmd_code;
    logic       p1_drop, p2_drop, p1_cooldown, p2_cooldown;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clock = ~clock;

    fighter_input_arbiter #(.COOLDOWN_CYCLES(C)) dut (
        .clock       (clock),
        .reset       (reset),
        .p1_buttons  (p1_buttons),
        .p2_buttons  (p2_buttons),
        .cmd_ready   (cmd_ready),
        .cmd_valid   (cmd_valid),
        .cmd_player  (cmd_player),
        .cmd_code    (cmd_code),
        .p1_drop     (p1_drop),
        .p2_drop     (p2_drop),
        .p1_cooldown (p1_cooldown),
        .p2_cooldown (p2_cooldown)
    );

    // Reference model: pending buffers are queues capped at one entry,
    // cooldown is derived from the edge number of the last attack handshake.
    logic [3:0] m_prev [2];
    logic [1:0] pq0 [$];
    logic [1:0] pq1 [$];
    logic       m_cv, m_cp, m_last;
    logic [1:0] m_cc;
    logic       m_drop [2];
    int         m_atk [2];
    int         edge_n;

    function automatic int m_cool(input int p, input int e);
        return (m_atk[p] >= 0 && (e - m_atk[p]) < C) ? 1 : 0;
    endfunction

    task automatic model_reset();
        m_prev[0] = '0; m_prev[1] = '0;
        pq0.delete(); pq1.delete();
        m_cv = 1'b0; m_cp = 1'b0; m_cc = 2'd0; m_last = 1'b1;
        m_drop[0] = 1'b0; m_drop[1] = 1'b0;
        m_atk[0] = -1; m_atk[1] = -1;
        edge_n = 0;
    endtask

    task automatic model_step(input logic [3:0] b1, input logic [3:0] b2, input logic rdy);
        logic [3:0] b [2];
        logic [3:0] pr;
        logic       hs_atk;
        int         hs_p, g, e, code;
        edge_n++;
        e = edge_n;
        b[0] = b1; b[1] = b2;
        hs_atk = m_cv && rdy && (m_cc == 2'd3);
        hs_p   = int'(m_cp);
        g = -1;
        if (!m_cv || rdy) begin
            if (pq0.size() > 0 && pq1.size() > 0) g = m_last ? 0 : 1;
            else if (pq0.size() > 0) g = 0;
            else if (pq1.size() > 0) g = 1;
            if (g == 0) begin
                m_cc = pq0.pop_front(); m_cv = 1'b1; m_cp = 1'b0; m_last = 1'b0;
            end else if (g == 1) begin
                m_cc = pq1.pop_front(); m_cv = 1'b1; m_cp = 1'b1; m_last = 1'b1;
            end else begin
                m_cv = 1'b0;
            end
        end
        for (int p = 0; p < 2; p++) begin
            pr = b[p] & ~m_prev[p];
            if (m_cool(p, e - 1) != 0) pr[3] = 1'b0;
            m_drop[p] = 1'b0;
            if (pr != 4'd0) begin
                code = 3;
                while (!pr[code]) code--;
                if (p == 0) begin
                    if (pq0.size() == 0) pq0.push_back(2'(code)); else m_drop[0] = 1'b1;
                end else begin
                    if (pq1.size() == 0) pq1.push_back(2'(code)); else m_drop[1] = 1'b1;
                end
            end
            m_prev[p] = b[p];
        end
        if (hs_atk) m_atk[hs_p] = e;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("cmd_valid", 32'(cmd_valid), 32'(m_cv));
        if (m_cv) begin
            chk("cmd_player", 32'(cmd_player), 32'(m_cp));
            chk("cmd_code", 32'(cmd_code), 32'(m_cc));
        end
        chk("p1_drop", 32'(p1_drop), 32'(m_drop[0]));
        chk("p2_drop", 32'(p2_drop), 32'(m_drop[1]));
        chk("p1_cooldown", 32'(p1_cooldown), 32'(m_cool(0, edge_n)));
        chk("p2_cooldown", 32'(p2_cooldown), 32'(m_cool(1, edge_n)));
    endtask

    // One clock: drive inputs, step the model at the edge, check at negedge.
    task automatic cyc(input logic [3:0] b1, input logic [3:0] b2, input logic rdy);
        p1_buttons = b1;
        p2_buttons = b2;
        cmd_ready  = rdy;
        @(posedge clock);
        model_step(b1, b2, rdy);
        @(negedge clock);
        check_all();
    endtask

    task automatic do_reset(input logic [3:0] b1);
        reset      = 1'b1;
        p1_buttons = b1;
        p2_buttons = '0;
        cmd_ready  = 1'b0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        model_reset();
        check_all();
    endtask

    initial begin
        logic [3:0] rb1, rb2;
        logic       rr;
        int         rights;

        // Reset state
        do_reset(4'd0);
        chk("rst_cmd_valid", 32'(cmd_valid), 0);
        chk("rst_cmd_player", 32'(cmd_player), 0);
        chk("rst_cmd_code", 32'(cmd_code), 0);
        chk("rst_drops", 32'({p1_drop, p2_drop}), 0);
        chk("rst_cooldowns", 32'({p1_cooldown, p2_cooldown}), 0);

        // Two-cycle latency of a single jump
        cyc(4'b0100, 4'b0000, 1'b1);
        chk("lat_early", 32'(cmd_valid), 0);
        cyc(4'b0000, 4'b0000, 1'b1);
        chk("lat_valid", 32'(cmd_valid), 1);
        chk("lat_player", 32'(cmd_player), 0);
        chk("lat_code", 32'(cmd_code), 2);
        cyc(4'b0000, 4'b0000, 1'b1);
        chk("lat_oneshot", 32'(cmd_valid), 0);

        // Tie after reset: player 1 first, then player 2
        do_reset(4'd0);
        cyc(4'b1000, 4'b0001, 1'b1);
        cyc(4'b0000, 4'b0000, 1'b1);
        chk("tie_first_player", 32'(cmd_player), 0);
        chk("tie_first_code", 32'(cmd_code), 3);
        cyc(4'b0000, 4'b0000, 1'b1);
        chk("tie_second_valid", 32'(cmd_valid), 1);
        chk("tie_second_player", 32'(cmd_player), 1);
        chk("tie_second_code", 32'(cmd_code), 0);
        cyc(4'b0000, 4'b0000, 1'b1);
        cyc(4'b0100, 4'b0010, 1'b1);
        repeat (3) cyc(4'b0000, 4'b0000, 1'b1);

        // Back-pressure, full pending, drop pulse
        cyc(4'b0010, 4'b0000, 1'b0);
        cyc(4'b0000, 4'b0000, 1'b0);
        cyc(4'b0001, 4'b0000, 1'b0);
        cyc(4'b0000, 4'b0000, 1'b0);
        chk("bp_hold_code", 32'(cmd_code), 1);
        cyc(4'b0100, 4'b0000, 1'b0);
        chk("bp_drop", 32'(p1_drop), 1);
        cyc(4'b0000, 4'b0000, 1'b0);
        chk("bp_drop_once", 32'(p1_drop), 0);
        chk("bp_still_right", 32'(cmd_code), 1);
        cyc(4'b0000, 4'b0000, 1'b1);
        chk("bp_left_next", 32'(cmd_code), 0);
        cyc(4'b0000, 4'b0000, 1'b1);
        chk("bp_drained", 32'(cmd_valid), 0);

        // Multi-press from player 2 encodes to a single attack
        repeat (6) cyc(4'b0000, 4'b0000, 1'b1);
        cyc(4'b0000, 4'b1011, 1'b1);
        cyc(4'b0000, 4'b0000, 1'b1);
        chk("multi_code", 32'(cmd_code), 3);
        chk("multi_player", 32'(cmd_player), 1);
        cyc(4'b0000, 4'b0000, 1'b1);
        chk("multi_single", 32'(cmd_valid), 0);

        // Cooldown window (handshake at edge 3)
        do_reset(4'd0);
        cyc(4'b1000, 4'b0000, 1'b1);
        cyc(4'b0000, 4'b0000, 1'b1);
        cyc(4'b0000, 4'b0000, 1'b1);
        chk("cd_active", 32'(p1_cooldown), 1);
        cyc(4'b1000, 4'b0000, 1'b1);
        cyc(4'b0000, 4'b0000, 1'b1);
        chk("cd_masked_none", 32'(cmd_valid), 0);
        chk("cd_masked_nodrop", 32'(p1_drop), 0);
        cyc(4'b0100, 4'b0000, 1'b1);
        cyc(4'b1000, 4'b0000, 1'b1);
        chk("cd_jump_code", 32'(cmd_code), 2);
        chk("cd_window_end", 32'(p1_cooldown), 0);
        cyc(4'b0000, 4'b0000, 1'b1);
        chk("cd_last_edge_masked", 32'(cmd_valid), 0);
        cyc(4'b1000, 4'b0000, 1'b1);
        cyc(4'b0000, 4'b0000, 1'b1);
        chk("cd_after_valid", 32'(cmd_valid), 1);
        chk("cd_after_code", 32'(cmd_code), 3);

        // Button held across reset gives exactly one command
        do_reset(4'b0010);
        rights = 0;
        repeat (5) begin
            cyc(4'b0010, 4'b0000, 1'b1);
            if (cmd_valid && cmd_code == 2'd1) rights++;
        end
        chk("held_one_right", 32'(rights), 1);

        // Asynchronous reset while a command is presented
        cyc(4'b0100, 4'b0000, 1'b0);
        cyc(4'b0000, 4'b0000, 1'b0);
        chk("async_pre", 32'(cmd_valid), 1);
        #2 reset = 1'b1;
        #1 chk("async_clear", 32'(cmd_valid), 0);
        do_reset(4'd0);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            rb1 = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : 4'd0;
            rb2 = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : 4'd0;
            rr  = ($urandom_range(0, 3) != 0);
            cyc(rb1, rb2, rr);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
